// File: rtl/uart_msg_sched.sv
// rtl/uart_msg_sched.sv - feeds latched ASCII messages byte-by-byte to the UART TX core
// Optional trailing XOR checksum byte: define UART_MSG_CHKSUM_EN.
module uart_msg_sched #(
    parameter int CNT1US   = 81,
    parameter int GAP_US   = 100,
    parameter int ACK_TO   = 16,
    parameter int MAXBYTES = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  msg_req_i,
    input  logic [8*MAXBYTES-1:0] msg_data_i,
    input  logic [5:0]            msg_len_i,
    input  logic                  tx_ready_i,
    output logic                  tx_start_o,
    output logic [7:0]            tx_byte_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  drop_o,
    output logic                  err_o
);
    localparam int DW      = 8 * MAXBYTES;
    localparam int GAP_CYC = GAP_US * CNT1US;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int ACK_W   = $clog2(ACK_TO) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TO - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_ACK, S_DRAIN, S_GAP} state_t;

    state_t           state_q, state_d;
    logic             act_valid_q, act_valid_d, pend_valid_q, pend_valid_d;
    logic [DW-1:0]    act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [DW-1:0]    work_q, work_d, aligned;
    logic [5:0]       act_len_q, act_len_d, pend_len_q, pend_len_d;
    logic [5:0]       k_q, k_d, last_k;
    logic [7:0]       byte_q, byte_d;
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             start_q, start_d, done_q, done_d, drop_q, drop_d, err_q, err_d;
    logic             len_bad, promote;
`ifdef UART_MSG_CHKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif

    // Left-align the right-justified string so byte k is always the top byte after k shifts.
    assign aligned = act_data_q << {6'(MAXBYTES) - act_len_q, 3'b000};
    assign len_bad = (msg_len_i == 6'd0) || (msg_len_i > 6'(MAXBYTES));
`ifdef UART_MSG_CHKSUM_EN
    assign last_k  = act_len_q;
`else
    assign last_k  = act_len_q - 6'd1;
`endif

    always_comb begin
        state_d      = state_q;
        act_valid_d  = act_valid_q;
        act_data_d   = act_data_q;
        act_len_d    = act_len_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        pend_len_d   = pend_len_q;
        work_d       = work_q;
        k_d          = k_q;
        byte_d       = byte_q;
        ack_cnt_d    = ack_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        start_d      = 1'b0;
        done_d       = 1'b0;
        drop_d       = 1'b0;
        err_d        = 1'b0;
        promote      = 1'b0;
`ifdef UART_MSG_CHKSUM_EN
        chk_d        = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (act_valid_q) begin
                    state_d = S_LOAD;
                end else if (pend_valid_q) begin
                    promote      = 1'b1;
                    act_valid_d  = 1'b1;
                    act_data_d   = pend_data_q;
                    act_len_d    = pend_len_q;
                    pend_valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                k_d     = 6'd0;
                byte_d  = aligned[DW-1 -: 8];
                work_d  = aligned << 8;
`ifdef UART_MSG_CHKSUM_EN
                chk_d   = 8'h00;
`endif
                state_d = S_START;
            end
            S_START: begin
                if (tx_ready_i) begin
                    start_d   = 1'b1;
                    ack_cnt_d = '0;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                if (!tx_ready_i) begin
                    state_d = S_DRAIN;
                end else if (ack_cnt_q == ACK_LAST) begin
                    err_d       = 1'b1;
                    act_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (tx_ready_i) begin
                    if (k_q == last_k) begin
                        done_d      = 1'b1;
                        act_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        k_d       = k_q + 6'd1;
                        byte_d    = work_q[DW-1 -: 8];
                        work_d    = work_q << 8;
`ifdef UART_MSG_CHKSUM_EN
                        chk_d     = chk_q ^ byte_q;
                        if (k_d == act_len_q) byte_d = chk_q ^ byte_q;
`endif
                        gap_cnt_d = '0;
                        state_d   = (GAP_CYC == 0) ? S_START : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_START;
                else gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A request coinciding with promotion lands in the slot being vacated.
        if (msg_req_i) begin
            if (len_bad) begin
                err_d = 1'b1;
            end else if (state_q == S_IDLE && !act_valid_q && !pend_valid_q) begin
                act_valid_d = 1'b1;
                act_data_d  = msg_data_i;
                act_len_d   = msg_len_i;
            end else if (!pend_valid_q || promote) begin
                pend_valid_d = 1'b1;
                pend_data_d  = msg_data_i;
                pend_len_d   = msg_len_i;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            act_valid_q  <= 1'b0;
            act_data_q   <= '0;
            act_len_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_len_q   <= '0;
            work_q       <= '0;
            k_q          <= '0;
            byte_q       <= '0;
            ack_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef UART_MSG_CHKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            act_valid_q  <= act_valid_d;
            act_data_q   <= act_data_d;
            act_len_q    <= act_len_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            pend_len_q   <= pend_len_d;
            work_q       <= work_d;
            k_q          <= k_d;
            byte_q       <= byte_d;
            ack_cnt_q    <= ack_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            start_q      <= start_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
`ifdef UART_MSG_CHKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign tx_start_o = start_q;
    assign tx_byte_o  = byte_q;
    assign done_o     = done_q;
    assign drop_o     = drop_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != S_IDLE) | act_valid_q | pend_valid_q;

endmodule
